hamming_secded_dec_pipe: RTL

HAMMING_SECDED_DEC_PIPE -- requirements
Module: hamming_secded_dec_pipe

---
 rtl/hamming_pkg.sv | 25 ++
 rtl/hamming_syn_calc.sv | 34 +++
 rtl/hamming_secded_dec_pipe.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/hamming_pkg.sv
// Shared definitions for the SECDED Hamming decoder: codeword layout helpers
// and the per-beat status classification.
package hamming_pkg;

  typedef enum logic [1:0] {
    CLEAN = 2'd0,
    SEC   = 2'd1,
    DED   = 2'd2
  } status_e;

  function automatic bit is_pow2(input int unsigned x);
    return (x != 0) && ((x & (x - 1)) == 0);
  endfunction

  // Codeword position (1-based) of data bit k: skip every power-of-two slot.
  function automatic int unsigned data_pos(input int unsigned k);
    int unsigned r;
    r = k + 1;
    for (int j = 0; j < 31; j++) begin
      if ((32'd1 << j) <= r) r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/hamming_syn_calc.sv
// Combinational syndrome and overall-parity computation over a received beat.
module hamming_syn_calc
  import hamming_pkg::*;
#(
  parameter int DW = 512,
  parameter int PW = 10
) (
  input  logic [DW-1:0] i_data,
  input  logic [PW-1:0] i_parity,
  input  logic          i_ovr_par,
  output logic [PW-1:0] o_syn,
  output logic          o_par
);

  logic [PW-1:0] term [DW];

  genvar gi;
  generate
    for (gi = 0; gi < DW; gi++) begin : g_term
      localparam int unsigned POS = data_pos(gi);
      assign term[gi] = i_data[gi] ? PW'(POS) : '0;
    end
  endgenerate

  always_comb begin
    o_syn = i_parity;
    for (int i = 0; i < DW; i++) begin
      o_syn = o_syn ^ term[i];
    end
  end

  assign o_par = (^i_data) ^ (^i_parity) ^ i_ovr_par;

endmodule

// File: rtl/hamming_secded_dec_pipe.sv
// Two-stage SECDED Hamming decoder with valid/ready flow control, saturating
// error counters and a sticky capture of the first erroneous syndrome.
module hamming_secded_dec_pipe
  import hamming_pkg::*;
#(
  parameter int DW = 512,
  parameter int PW = 10,
  parameter int CW = 16
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_valid,
  output logic          o_ready,
  input  logic [DW-1:0] i_dec_data,
  input  logic [PW-1:0] i_parity,
  input  logic          i_ovr_par,
  output logic          o_valid,
  input  logic          i_ready,
  output logic [DW-1:0] o_dec_data,
  output logic [PW-1:0] o_err_pos,
  output logic          o_sec,
  output logic          o_ded,
  input  logic          i_cnt_clr,
  output logic [CW-1:0] o_cnt_sec,
  output logic [CW-1:0] o_cnt_ded,
  output logic          o_first_vld,
  output logic [PW-1:0] o_first_pos
);

  if (2 ** PW < DW + PW + 1) begin : g_pw_check
    $error("hamming_secded_dec_pipe: PW too small to cover DW data bits");
  end

  localparam logic [PW-1:0] MAX_POS = PW'(DW + PW);

  logic [PW-1:0] syn;
  logic          par;

  hamming_syn_calc #(.DW(DW), .PW(PW)) u_syn (
    .i_data   (i_dec_data),
    .i_parity (i_parity),
    .i_ovr_par(i_ovr_par),
    .o_syn    (syn),
    .o_par    (par)
  );

  logic          s1_vld_q, s1_vld_d;
  logic [DW-1:0] s1_data_q, s1_data_d;
  logic [PW-1:0] s1_syn_q, s1_syn_d;
  logic          s1_par_q, s1_par_d;
  logic          s2_vld_q, s2_vld_d;
  logic [DW-1:0] s2_data_q, s2_data_d;
  logic [PW-1:0] s2_syn_q, s2_syn_d;
  status_e       s2_status_q, s2_status_d;
  logic [CW-1:0] cnt_sec_q, cnt_sec_d;
  logic [CW-1:0] cnt_ded_q, cnt_ded_d;
  logic          first_vld_q, first_vld_d;
  logic [PW-1:0] first_pos_q, first_pos_d;

  logic          s1_load, s2_load, out_hs;
  status_e       status;
  logic [DW-1:0] flip_mask, corr;

  // One-hot mask of the data bit sitting at the stage-1 syndrome position.
  genvar gi;
  generate
    for (gi = 0; gi < DW; gi++) begin : g_flip
      localparam int unsigned POS = data_pos(gi);
      assign flip_mask[gi] = (s1_syn_q == PW'(POS));
    end
  endgenerate

  always_comb begin
    s2_load = !s2_vld_q || i_ready;
    s1_load = !s1_vld_q || s2_load;
    out_hs  = s2_vld_q && i_ready;

    s1_vld_d  = s1_vld_q;
    s1_data_d = s1_data_q;
    s1_syn_d  = s1_syn_q;
    s1_par_d  = s1_par_q;
    if (s1_load) begin
      s1_vld_d  = i_valid;
      s1_data_d = i_dec_data;
      s1_syn_d  = syn;
      s1_par_d  = par;
    end

    // Odd overall parity with a zero or check-bit syndrome is a single error
    // outside the data field, so it counts as corrected with data untouched.
    status = CLEAN;
    corr   = s1_data_q;
    if (s1_par_q) begin
      if (s1_syn_q > MAX_POS) begin
        status = DED;
      end else begin
        status = SEC;
        if (s1_syn_q != '0 && !is_pow2(32'(s1_syn_q))) corr = s1_data_q ^ flip_mask;
      end
    end else if (s1_syn_q != '0) begin
      status = DED;
    end

    s2_vld_d    = s2_vld_q;
    s2_data_d   = s2_data_q;
    s2_syn_d    = s2_syn_q;
    s2_status_d = s2_status_q;
    if (s2_load) begin
      s2_vld_d    = s1_vld_q;
      s2_data_d   = corr;
      s2_syn_d    = s1_syn_q;
      s2_status_d = status;
    end

    cnt_sec_d   = cnt_sec_q;
    cnt_ded_d   = cnt_ded_q;
    first_vld_d = first_vld_q;
    first_pos_d = first_pos_q;
    if (i_cnt_clr) begin
      cnt_sec_d   = '0;
      cnt_ded_d   = '0;
      first_vld_d = 1'b0;
      first_pos_d = '0;
    end else if (out_hs && s2_status_q != CLEAN) begin
      if (s2_status_q == SEC && cnt_sec_q != '1) cnt_sec_d = cnt_sec_q + CW'(1);
      if (s2_status_q == DED && cnt_ded_q != '1) cnt_ded_d = cnt_ded_q + CW'(1);
      if (!first_vld_q) begin
        first_vld_d = 1'b1;
        first_pos_d = s2_syn_q;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      s1_vld_q    <= 1'b0;
      s2_vld_q    <= 1'b0;
      cnt_sec_q   <= '0;
      cnt_ded_q   <= '0;
      first_vld_q <= 1'b0;
      first_pos_q <= '0;
    end else begin
      s1_vld_q    <= s1_vld_d;
      s2_vld_q    <= s2_vld_d;
      cnt_sec_q   <= cnt_sec_d;
      cnt_ded_q   <= cnt_ded_d;
      first_vld_q <= first_vld_d;
      first_pos_q <= first_pos_d;
    end
  end

  always_ff @(posedge i_clk) begin
    s1_data_q   <= s1_data_d;
    s1_syn_q    <= s1_syn_d;
    s1_par_q    <= s1_par_d;
    s2_data_q   <= s2_data_d;
    s2_syn_q    <= s2_syn_d;
    s2_status_q <= s2_status_d;
  end

  assign o_ready     = s1_load;
  assign o_valid     = s2_vld_q;
  assign o_dec_data  = s2_data_q;
  assign o_err_pos   = s2_syn_q;
  assign o_sec       = (s2_status_q == SEC);
  assign o_ded       = (s2_status_q == DED);
  assign o_cnt_sec   = cnt_sec_q;
  assign o_cnt_ded   = cnt_ded_q;
  assign o_first_vld = first_vld_q;
  assign o_first_pos = first_pos_q;

endmodule
